// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the UART-to-register-file/ALU system controller:
// width defaults, frame command codes, operand addresses and FSM states.
package sys_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned FUN_W_DEF  = 4;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUN,
    ALU_WAIT,
    TX_RD,
    TX_LSB,
    TX_MSB
  } state_t;

endpackage

// File: rtl/sys_ctrl.sv
// System controller: decodes UART command frames into register-file and ALU
// operations and returns read/ALU results through the UART transmitter.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned FUN_W  = FUN_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   RX_P_DATA,
  input  logic                RX_D_VLD,
  output logic                WrEn,
  output logic                RdEn,
  output logic [ADDR_W-1:0]   Address,
  output logic [DATA_W-1:0]   WrData,
  input  logic [DATA_W-1:0]   RdData,
  input  logic                RdData_Valid,
  output logic                ALU_EN,
  output logic [FUN_W-1:0]    ALU_FUN,
  input  logic [2*DATA_W-1:0] ALU_OUT,
  input  logic                OUT_VALID,
  output logic                CLK_GATE_EN,
  output logic [DATA_W-1:0]   TX_P_DATA,
  output logic                TX_D_VLD,
  input  logic                TX_BUSY
);

  state_t              state;
  logic [DATA_W-1:0]   alu_msb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      TX_P_DATA   <= '0;
      alu_msb     <= '0;
    end else begin
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      ALU_EN <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == DATA_W'(CMD_RF_WR)) begin
              state <= WR_ADDR;
            end else if (RX_P_DATA == DATA_W'(CMD_RF_RD)) begin
              state <= RD_ADDR;
            end else if (RX_P_DATA == DATA_W'(CMD_ALU_OP)) begin
              state <= OPA;
            end else if (RX_P_DATA == DATA_W'(CMD_ALU_NOP)) begin
              state       <= FUN;
              CLK_GATE_EN <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrEn   <= 1'b1;
            WrData <= RX_P_DATA;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            RdEn    <= 1'b1;
            state   <= RD_WAIT;
          end
        end
        // The read result is captured straight into the TX holding register.
        RD_WAIT: begin
          if (RdData_Valid) begin
            TX_P_DATA <= RdData;
            TX_D_VLD  <= 1'b1;
            state     <= TX_RD;
          end
        end
        OPA: begin
          if (RX_D_VLD) begin
            WrEn    <= 1'b1;
            Address <= ADDR_W'(OPA_ADDR);
            WrData  <= RX_P_DATA;
            state   <= OPB;
          end
        end
        OPB: begin
          if (RX_D_VLD) begin
            WrEn        <= 1'b1;
            Address     <= ADDR_W'(OPB_ADDR);
            WrData      <= RX_P_DATA;
            CLK_GATE_EN <= 1'b1;
            state       <= FUN;
          end
        end
        FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[FUN_W-1:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_WAIT;
          end
        end
        // LSB goes directly to the TX register; only the MSB needs holding.
        ALU_WAIT: begin
          if (OUT_VALID) begin
            TX_P_DATA   <= ALU_OUT[DATA_W-1:0];
            alu_msb     <= ALU_OUT[2*DATA_W-1:DATA_W];
            TX_D_VLD    <= 1'b1;
            CLK_GATE_EN <= 1'b0;
            state       <= TX_LSB;
          end
        end
        TX_LSB: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= alu_msb;
            state     <= TX_MSB;
          end
        end
        TX_MSB, TX_RD: begin
          if (!TX_BUSY) begin
            TX_D_VLD <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, for the operand, register-file and UART byte width.
REQ-002 SHALL have parameter ADDR_W, default 4, for the register-file address width.
REQ-003 SHALL have parameter FUN_W, default 4, for the ALU function-code width.
REQ-004 SHALL have ports: CLK  in  1  single clock; RST  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: RX_P_DATA  in  DATA_W  received byte; RX_D_VLD  in  1  one-cycle strobe marking a new byte.
REQ-006 SHALL have ports: WrEn, RdEn  out  1  RF strobes; Address  out  ADDR_W; WrData  out  DATA_W; RdData  in  DATA_W; RdData_Valid  in  1  read result strobe.
REQ-007 SHALL have ports: ALU_EN  out  1  ALU operate strobe; ALU_FUN  out  FUN_W; ALU_OUT  in  2*DATA_W; OUT_VALID  in  1  ALU result strobe.
REQ-008 SHALL have ports: CLK_GATE_EN  out  1  ALU clock-gate enable; TX_P_DATA  out  DATA_W; TX_D_VLD  out  1; TX_BUSY  in  1  transmitter cannot accept.

Function
REQ-009 SHALL decode the first byte of each frame as a command: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands; other bytes are ignored and the FSM stays in IDLE.
REQ-010 SHALL implement the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_RD, TX_LSB and TX_MSB, advancing between byte-consuming states only on RX_D_VLD=1.
REQ-011 SHALL, for 0xAA, latch addr[ADDR_W-1:0] in WR_ADDR; on the data byte, pulse WrEn for exactly one cycle with the latched Address and WrData=data; then return to IDLE with no TX.
REQ-012 SHALL, for 0xBB, pulse RdEn for exactly one cycle on the address byte, then wait in RD_WAIT for RdData_Valid, capture RdData, and go to TX_RD.
REQ-013 SHALL, for 0xCC, write operand A to address 0 and operand B to address 1 (one WrEn pulse each) in OPA and OPB, then go to FUN; 0xDD SHALL go directly to FUN.
REQ-014 SHALL, in FUN on the byte arrival, drive ALU_FUN=byte[FUN_W-1:0], pulse ALU_EN for one cycle, then wait in ALU_WAIT for OUT_VALID and capture ALU_OUT.
REQ-015 SHALL hold CLK_GATE_EN=1 from entry to FUN until the ALU_OUT capture, and 0 at all other times.
REQ-016 SHALL send the captured ALU result as two bytes, LSB (TX_LSB) then MSB (TX_MSB); a read result SHALL be sent as one byte (TX_RD).
REQ-017 SHALL treat a TX byte as transferred in a cycle with TX_D_VLD=1 and TX_BUSY=0; while TX_BUSY=1, TX_D_VLD and TX_P_DATA SHALL stay stable.
REQ-018 SHALL never assert WrEn and RdEn in the same cycle.
REQ-019 SHALL ignore RX_D_VLD while in RD_WAIT, ALU_WAIT or any TX state, with no buffering; the dropped bytes are lost.
REQ-020 SHALL hold in a wait state indefinitely with no timeout; only reset exits it.
REQ-021 SHALL register all outputs; latency from the final command byte's RX_D_VLD to the WrEn, RdEn or ALU_EN pulse SHALL be 1 cycle.

Reset
REQ-022 SHALL, on RST=1, asynchronously force state IDLE, all strobes (WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_GATE_EN) to 0, and Address, WrData, ALU_FUN, TX_P_DATA and the capture registers to 0.
REQ-023 SHALL abort any frame or pending TX when RST is asserted mid-operation; after release, the next byte SHALL be decoded as a command.

Structure
REQ-024 SHALL take the command codes (0xAA/0xBB/0xCC/0xDD), the operand A/B addresses (0, 1) and the width defaults from the shared macros/package, and SHALL take the state encoding from that same source.
REQ-025 SHALL be a single module with no sub-modules; a TX byte-sequencer sub-module is not warranted.

Verification
REQ-026 SHALL verify: RX AA,05,3C -> one-cycle WrEn with Address=5, WrData=0x3C; no TX_D_VLD.
REQ-027 SHALL verify: RX BB,05, RdData_Valid with RdData=0x3C 3 cycles later -> RdEn pulse with Address=5, then TX_P_DATA=0x3C.
REQ-028 SHALL verify: RX CC,0A,03,00, ALU_OUT=0x000D with OUT_VALID -> writes to addresses 0 and 1, ALU_EN with ALU_FUN=0, TX bytes 0x0D then 0x00.
REQ-029 SHALL verify: RX DD,02 with TX_BUSY=1 for 10 cycles -> TX_P_DATA held stable, first TX byte transferred only after TX_BUSY falls.
REQ-030 SHALL verify: RX 0x55 then AA,01,FF -> 0x55 ignored, write to address 1 of 0xFF.
REQ-031 SHALL verify: RST pulsed in ALU_WAIT -> all outputs 0, then RX BB,00 is handled as a new read.
